// File: rtl/relu_maxpool2x2.sv
// ReLU + 2x2/stride-2 max pooling over a channel-major feature map held in BRAM.
// Each output takes five cycles: four tap reads and one fold/write cycle.
module relu_maxpool2x2 #(
    parameter int CHANNELS       = 64,
    parameter int HEIGHT         = 14,
    parameter int WIDTH          = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int IN_ADDR_WIDTH  = 14,
    parameter int OUT_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr,
    output logic                      in_en,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_we,
    output logic                      busy,
    output logic                      done
);

    localparam int NUM_OUT = CHANNELS * (HEIGHT / 2) * (WIDTH / 2);
    localparam int PC_W    = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_OUT = OUT_ADDR_WIDTH'(NUM_OUT - 1);
    localparam logic [OUT_ADDR_WIDTH-1:0] OUT_ONE  = OUT_ADDR_WIDTH'(1);
    localparam logic [PC_W-1:0]           PC_LAST  = PC_W'(WIDTH / 2 - 1);
    localparam logic [PC_W-1:0]           PC_ONE   = PC_W'(1);
    localparam logic [IN_ADDR_WIDTH-1:0]  IN_ONE   = IN_ADDR_WIDTH'(1);
    localparam logic [IN_ADDR_WIDTH-1:0]  ROW_OFF  = IN_ADDR_WIDTH'(WIDTH);
    localparam logic [IN_ADDR_WIDTH-1:0]  PC_STEP  = IN_ADDR_WIDTH'(2);
    localparam logic [IN_ADDR_WIDTH-1:0]  ROW_STEP = IN_ADDR_WIDTH'(WIDTH + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    if (HEIGHT % 2 != 0) begin : g_bad_height
        $error("relu_maxpool2x2: HEIGHT must be even");
    end
    if (WIDTH % 2 != 0) begin : g_bad_width
        $error("relu_maxpool2x2: WIDTH must be even");
    end

    logic [1:0]                      state;
    logic [1:0]                      k;
    logic [IN_ADDR_WIDTH-1:0]        base;
    logic [IN_ADDR_WIDTH-1:0]        next_base;
    logic [PC_W-1:0]                 pc;
    logic [OUT_ADDR_WIDTH-1:0]       out_idx;
    logic signed [DATA_WIDTH-1:0]    run_max;
    logic signed [DATA_WIDTH-1:0]    folded;

    assign folded = ($signed(in_data) > run_max) ? $signed(in_data) : run_max;

    // Moving from the last column pair to the next row pair (or the next channel,
    // since HEIGHT is even) is the same +WIDTH+2 step from the current tap 0.
    assign next_base = base + ((pc == PC_LAST) ? ROW_STEP : PC_STEP);

    // NOTE: every register below uses non-blocking assignment so all state updates
    // see the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= 2'd0;
            base     <= '0;
            pc       <= '0;
            out_idx  <= '0;
            run_max  <= '0;
            in_addr  <= '0;
            in_en    <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            out_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            out_we <= 1'b0;
            done   <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        k       <= 2'd0;
                        base    <= '0;
                        pc      <= '0;
                        out_idx <= '0;
                        in_addr <= '0;
                        in_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                ISSUE: begin
                    // Starting from 0 makes the max the ReLU of the window.
                    run_max <= (k == 2'd0) ? '0 : folded;
                    if (k == 2'd3) begin
                        state <= FINAL;
                        in_en <= 1'b0;
                    end else begin
                        k       <= k + 2'd1;
                        in_en   <= 1'b1;
                        in_addr <= k[0] ? (base + ROW_OFF) : (in_addr + IN_ONE);
                    end
                end

                FINAL: begin
                    out_data <= folded;
                    out_addr <= out_idx;
                    out_we   <= 1'b1;
                    if (out_idx == LAST_OUT) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state   <= ISSUE;
                        k       <= 2'd0;
                        base    <= next_base;
                        in_addr <= next_base;
                        in_en   <= 1'b1;
                        pc      <= (pc == PC_LAST) ? '0 : pc + PC_ONE;
                        out_idx <= out_idx + OUT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    in_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench: a 1x2x2 instance for single-window cases and a default-size
// instance checked cycle by cycle against a software ReLU + 2x2 max-pool model.
module tb_relu_maxpool2x2;

    localparam int C     = 64;
    localparam int H     = 14;
    localparam int W     = 16;
    localparam int NIN   = C * H * W;
    localparam int NOUT  = C * (H / 2) * (W / 2);
    localparam int LAST  = 5 * NOUT + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, act, act, exp, exp, $time);
        end
    endtask

    // Small 1x2x2 instance
    logic       s_start = 1'b0;
    logic [1:0] s_in_addr;
    logic       s_in_en;
    logic [7:0] s_in_data = '0;
    logic [0:0] s_out_addr;
    logic [7:0] s_out_data;
    logic       s_out_we, s_busy, s_done;
    logic [7:0] s_mem [4];

    relu_maxpool2x2 #(
        .CHANNELS(1), .HEIGHT(2), .WIDTH(2), .DATA_WIDTH(8),
        .IN_ADDR_WIDTH(2), .OUT_ADDR_WIDTH(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .in_addr(s_in_addr), .in_en(s_in_en), .in_data(s_in_data),
        .out_addr(s_out_addr), .out_data(s_out_data), .out_we(s_out_we),
        .busy(s_busy), .done(s_done)
    );

    always @(posedge clk) if (s_in_en) s_in_data <= s_mem[s_in_addr];

    // Default-size instance
    logic        d_start = 1'b0;
    logic [13:0] d_in_addr;
    logic        d_in_en;
    logic [7:0]  d_in_data = '0;
    logic [11:0] d_out_addr;
    logic [7:0]  d_out_data;
    logic        d_out_we, d_busy, d_done;
    logic [7:0]  d_mem [NIN];

    relu_maxpool2x2 u_dut (
        .clk(clk), .rst_n(rst_n), .start(d_start),
        .in_addr(d_in_addr), .in_en(d_in_en), .in_data(d_in_data),
        .out_addr(d_out_addr), .out_data(d_out_data), .out_we(d_out_we),
        .busy(d_busy), .done(d_done)
    );

    always @(posedge clk) if (d_in_en) d_in_data <= d_mem[d_in_addr];

    function automatic int tap_addr(input int p, input int k);
        int c, rem, pr, pc;
        c   = p / ((H / 2) * (W / 2));
        rem = p % ((H / 2) * (W / 2));
        pr  = rem / (W / 2);
        pc  = rem % (W / 2);
        return c * H * W + (2 * pr + k / 2) * W + 2 * pc + k % 2;
    endfunction

    function automatic logic [7:0] pool_model(input int p);
        logic signed [7:0] m;
        logic signed [7:0] v;
        m = 8'sd0;
        for (int k = 0; k < 4; k++) begin
            v = d_mem[tap_addr(p, k)];
            if (v > m) m = v;
        end
        return m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_en"},   {31'd0, s_in_en}, 32'd0);
        check({tag, "_s_we"},   {31'd0, s_out_we}, 32'd0);
        check({tag, "_s_done"}, {31'd0, s_done}, 32'd0);
        check({tag, "_d_en"},   {31'd0, d_in_en}, 32'd0);
        check({tag, "_d_we"},   {31'd0, d_out_we}, 32'd0);
        check({tag, "_d_done"}, {31'd0, d_done}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_idle_outputs(tag);
        check({tag, "_s_addr"}, {30'd0, s_in_addr}, 32'd0);
        check({tag, "_s_oaddr"}, {31'd0, s_out_addr}, 32'd0);
        check({tag, "_s_odata"}, {24'd0, s_out_data}, 32'd0);
        check({tag, "_s_busy"}, {31'd0, s_busy}, 32'd0);
        check({tag, "_d_addr"}, {18'd0, d_in_addr}, 32'd0);
        check({tag, "_d_oaddr"}, {20'd0, d_out_addr}, 32'd0);
        check({tag, "_d_odata"}, {24'd0, d_out_data}, 32'd0);
        check({tag, "_d_busy"}, {31'd0, d_busy}, 32'd0);
    endtask

    task automatic small_pass(input string tag, input logic [7:0] exp_data);
        @(negedge clk);
        s_start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            s_start = 1'b0;
            check({tag, "_en"}, {31'd0, s_in_en}, (n >= 1 && n <= 4) ? 32'd1 : 32'd0);
            if (n <= 4) check({tag, "_addr"}, {30'd0, s_in_addr}, n - 1);
            check({tag, "_we"},   {31'd0, s_out_we}, (n == 6) ? 32'd1 : 32'd0);
            check({tag, "_done"}, {31'd0, s_done},   (n == 6) ? 32'd1 : 32'd0);
            check({tag, "_busy"}, {31'd0, s_busy},   (n <= 6) ? 32'd1 : 32'd0);
            if (n == 6) begin
                check({tag, "_oaddr"}, {31'd0, s_out_addr}, 32'd0);
                check({tag, "_odata"}, {24'd0, s_out_data}, {24'd0, exp_data});
            end
        end
    endtask

    // Full default pass; abort_after > 0 re-pulses start mid-pass and asserts
    // reset right after that many writes have been seen.
    task automatic default_pass(input string tag, input int abort_after);
        int writes;
        int p, k;
        writes = 0;
        @(negedge clk);
        d_start = 1'b1;
        for (int n = 1; n <= LAST + 2; n++) begin
            @(negedge clk);
            d_start = (abort_after > 0 && n == 53) ? 1'b1 : 1'b0;
            p = (n - 1) / 5;
            k = (n - 1) % 5;
            if (n <= 5 * NOUT) begin
                check({tag, "_en"}, {31'd0, d_in_en}, (k < 4) ? 32'd1 : 32'd0);
                if (k < 4) check({tag, "_tap"}, {18'd0, d_in_addr}, tap_addr(p, k));
            end
            check({tag, "_we"}, {31'd0, d_out_we},
                  (n >= 6 && n % 5 == 1 && n <= LAST) ? 32'd1 : 32'd0);
            check({tag, "_done"}, {31'd0, d_done}, (n == LAST) ? 32'd1 : 32'd0);
            check({tag, "_busy"}, {31'd0, d_busy}, (n <= LAST) ? 32'd1 : 32'd0);
            if (d_out_we) begin
                check({tag, "_oaddr"}, {20'd0, d_out_addr}, writes);
                check({tag, "_odata"}, {24'd0, d_out_data}, {24'd0, pool_model(writes)});
                writes++;
            end
            if (abort_after > 0 && writes == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_rst"});
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    check_idle_outputs({tag, "_post"});
                end
                return;
            end
        end
        check({tag, "_count"}, writes, (abort_after > 0) ? abort_after : NOUT);
    endtask

    initial begin
        for (int a = 0; a < NIN; a++) d_mem[a] = 8'((a % 100) - 50);

        // Test 1: reset values, then quiet idle
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle_outputs("idle");
        end

        // Test 2: single window, positive max
        s_mem[0] = 8'hFB; s_mem[1] = 8'd3; s_mem[2] = 8'd7; s_mem[3] = 8'hFF;
        small_pass("win_pos", 8'd7);

        // Test 3: all-negative window including -128 -> ReLU gives 0
        s_mem[0] = 8'hFF; s_mem[1] = 8'h80; s_mem[2] = 8'hFE; s_mem[3] = 8'hFD;
        small_pass("win_neg", 8'd0);

        // Tests 4 and 5: full default pass with every tap address checked
        default_pass("full", 0);

        // Test 6: ignored re-start, mid-pass reset, then a clean full pass
        default_pass("abort", 100);
        default_pass("rerun", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
